// File: rtl/global_pkg.sv
// rtl/global_pkg.sv - shared RAM map and DMA state type
// RAM layout used by the DMA engine and its state encoding.
package global_pkg;

  localparam logic [7:0] DMA_RX_BASE = 8'h00;
  localparam logic [7:0] NEW_INST    = 8'h03;
  localparam logic [7:0] DMA_TX_BASE = 8'h04;

  typedef enum logic [3:0] {
    IDLE,
    RX_REQ,
    RX_WRITE,
    RX_FLAG,
    TX_REQ,
    TX_READ,
    TX_CAPT,
    TX_SEND,
    TX_WAIT
  } dma_state_t;

endpackage

// File: rtl/dma.sv
// rtl/dma.sv - bus-master DMA between serial RX/TX and the data RAM
// Drains the RX FIFO into the RAM receive buffer and feeds two RAM bytes to the transmitter.
module dma
  import global_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] RX_Data,
  input  logic       RX_Empty,
  output logic       Data_Read,
  input  logic       Send,
  output logic       Ready,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       Ack_out,
  input  logic       TX_RDY,
  output logic       Dma_Rq,
  input  logic       Dma_Ack,
  output logic       Cs,
  output logic       Wen,
  output logic       Oen,
  output logic [7:0] Address,
  output logic [7:0] DataOut,
  input  logic [7:0] DataIn
);

  dma_state_t state, state_nx;
  logic [1:0] idx, idx_nx;
  logic       txi, txi_nx;
  logic       send_pend;
  logic [7:0] tx_data_q;
  logic       tx_capt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      txi       <= 1'b0;
      send_pend <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      txi   <= txi_nx;
      // A new Send wins over the clear so a pulse coinciding with TX_REQ entry is not lost.
      if (Send)
        send_pend <= 1'b1;
      else if (state == IDLE && state_nx == TX_REQ)
        send_pend <= 1'b0;
      if (tx_capt)
        tx_data_q <= DataIn;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    txi_nx    = txi;
    Cs        = 1'b0;
    Wen       = 1'b0;
    Oen       = 1'b0;
    Address   = 8'h00;
    DataOut   = 8'h00;
    Data_Read = 1'b0;
    Valid_D   = 1'b0;
    tx_capt   = 1'b0;
    Dma_Rq    = (state != IDLE);

    case (state)
      IDLE: begin
        if (!RX_Empty)
          state_nx = RX_REQ;
        else if (send_pend)
          state_nx = TX_REQ;
      end

      RX_REQ: begin
        if (Dma_Ack)
          state_nx = RX_WRITE;
      end

      // Without the grant every bus state holds still and drives nothing.
      RX_WRITE: begin
        if (Dma_Ack) begin
          if (RX_Empty) begin
            state_nx = IDLE;
          end else begin
            Cs        = 1'b1;
            Wen       = 1'b1;
            Address   = DMA_RX_BASE + {6'd0, idx};
            DataOut   = RX_Data;
            Data_Read = 1'b1;
            if (idx == 2'd2) begin
              state_nx = RX_FLAG;
            end else begin
              idx_nx = idx + 2'd1;
            end
          end
        end
      end

      RX_FLAG: begin
        if (Dma_Ack) begin
          Cs       = 1'b1;
          Wen      = 1'b1;
          Address  = NEW_INST;
          DataOut  = 8'hFF;
          idx_nx   = 2'd0;
          state_nx = IDLE;
        end
      end

      TX_REQ: begin
        if (Dma_Ack)
          state_nx = TX_READ;
      end

      TX_READ: begin
        if (Dma_Ack) begin
          Cs       = 1'b1;
          Oen      = 1'b1;
          Address  = DMA_TX_BASE + {7'd0, txi};
          state_nx = TX_CAPT;
        end
      end

      TX_CAPT: begin
        tx_capt  = 1'b1;
        state_nx = TX_SEND;
      end

      TX_SEND: begin
        if (TX_RDY)
          state_nx = TX_WAIT;
      end

      TX_WAIT: begin
        Valid_D = 1'b1;
        if (Ack_out) begin
          if (!txi) begin
            txi_nx   = 1'b1;
            state_nx = TX_READ;
          end else begin
            txi_nx   = 1'b0;
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign Ready   = (state == IDLE) && RX_Empty && !send_pend && !Rst;
  assign TX_Data = tx_data_q;

endmodule

// File: tb/tb_dma.sv
// tb/tb_dma.sv - self-checking bench for the dma engine
// FIFO, RAM, transmitter and bus arbiter models plus a frame-level reference model.
module tb_dma;
  import global_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Empty;
  logic       Data_Read;
  logic       Send;
  logic       Ready;
  logic [7:0] TX_Data;
  logic       Valid_D;
  logic       Ack_out;
  logic       TX_RDY;
  logic       Dma_Rq;
  logic       Dma_Ack;
  logic       Cs, Wen, Oen;
  logic [7:0] Address, DataOut, DataIn;

  logic       grant_en;
  logic [7:0] tx_b0, tx_b1;

  dma u_dma (
    .Clk(Clk), .Rst(Rst), .RX_Data(RX_Data), .RX_Empty(RX_Empty), .Data_Read(Data_Read),
    .Send(Send), .Ready(Ready), .TX_Data(TX_Data), .Valid_D(Valid_D), .Ack_out(Ack_out),
    .TX_RDY(TX_RDY), .Dma_Rq(Dma_Rq), .Dma_Ack(Dma_Ack), .Cs(Cs), .Wen(Wen), .Oen(Oen),
    .Address(Address), .DataOut(DataOut), .DataIn(DataIn)
  );

  always #5 Clk = ~Clk;

  // FIFO (first-word fall-through); reset discards its contents
  logic [7:0] fifo_mem [0:255];
  int wr_ptr;
  int rd_ptr;
  assign RX_Empty = (rd_ptr == wr_ptr);
  assign RX_Data  = fifo_mem[rd_ptr[7:0]];
  always @(posedge Clk or posedge Rst) begin
    if (Rst) rd_ptr <= wr_ptr;
    else if (Data_Read) rd_ptr <= rd_ptr + 1;
  end

  assign Dma_Ack = grant_en & Dma_Rq;

  logic [7:0] ram [0:255];
  logic [7:0] rdata;
  assign DataIn = rdata;
  always @(posedge Clk) begin
    if (Cs && Wen) ram[Address] <= DataOut;
    if (Cs && Oen)
      rdata <= (Address == DMA_TX_BASE) ? tx_b0 :
               (Address == DMA_TX_BASE + 8'd1) ? tx_b1 : ram[Address];
  end

  always @(posedge Clk or posedge Rst) begin
    if (Rst) Ack_out <= 1'b0;
    else Ack_out <= Valid_D && !Ack_out;
  end

  // bus/transfer monitor
  int wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$], tx_got[$], vr_c[$];
  int cyc, pops, bus_viol;
  logic valid_prev;
  always @(posedge Clk) begin
    if (Cs && Wen) begin
      wr_a.push_back(int'(Address)); wr_d.push_back(int'(DataOut)); wr_c.push_back(cyc);
    end
    if (Cs && Oen) begin
      rd_a.push_back(int'(Address)); rd_c.push_back(cyc);
    end
    if (Data_Read) pops++;
    if ((Cs || Data_Read) && !Dma_Ack) bus_viol++;
    if (Valid_D && Ack_out) tx_got.push_back(int'(TX_Data));
    if (Valid_D && valid_prev !== 1'b1) vr_c.push_back(cyc);
    valid_prev = Valid_D;
    cyc++;
  end

  // reference model: frames of three bytes at consecutive slots, flag after each frame
  int exp_wa[$], exp_wd[$], exp_tx[$];
  int rx_slot, exp_pops;
  int wchk, tchk;
  int checks, failures;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_rx(input logic [7:0] b);
    exp_wa.push_back(int'(DMA_RX_BASE) + rx_slot);
    exp_wd.push_back(int'(b));
    exp_pops++;
    rx_slot++;
    if (rx_slot == 3) begin
      exp_wa.push_back(int'(NEW_INST));
      exp_wd.push_back(255);
      rx_slot = 0;
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_raw(b);
    model_rx(b);
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int k;
    k = 0;
    do begin
      @(negedge Clk);
      Send = 1'b0;
      if (rnd) begin
        grant_en = ($urandom % 4) != 0;
        TX_RDY   = ($urandom % 3) != 0;
      end
      k++;
    end while (!Ready && k < 400);
    grant_en = 1'b1;
    TX_RDY   = 1'b1;
    check({tag, "_idle"}, int'(Ready), 1);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nwr"}, wr_a.size(), exp_wa.size());
    for (int i = wchk; i < exp_wa.size(); i++) begin
      check({tag, "_waddr"}, qat(wr_a, i), exp_wa[i]);
      check({tag, "_wdata"}, qat(wr_d, i), exp_wd[i]);
    end
    wchk = exp_wa.size();
    check({tag, "_pops"}, pops, exp_pops);
    check({tag, "_ntx"}, tx_got.size(), exp_tx.size());
    for (int i = tchk; i < exp_tx.size(); i++)
      check({tag, "_txdata"}, qat(tx_got, i), exp_tx[i]);
    tchk = exp_tx.size();
  endtask

  initial begin
    int p, s, wb, rb, vb, k;
    logic [7:0] b;
    bit do_send;
    Send = 1'b0; TX_RDY = 1'b1; grant_en = 1'b1;
    tx_b0 = 8'h00; tx_b1 = 8'h00;

    // reset state
    @(negedge Clk);
    check("rst_ready", int'(Ready), 0);
    check("rst_rq", int'(Dma_Rq), 0);
    check("rst_bus", int'({Cs, Wen, Oen, Data_Read, Valid_D}), 0);
    check("rst_addr", int'(Address), 0);
    check("rst_dout", int'(DataOut), 0);
    check("rst_txdata", int'(TX_Data), 0);
    Rst = 1'b0;
    #1 check("ready_after_rst", int'(Ready), 1);

    // RX frame, immediate grant
    @(negedge Clk);
    wb = wr_a.size(); p = cyc;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_idle("rx", 0);
    compare_logs("rx");
    check("rx_lat", qat(wr_c, wb), p + 2);
    check("rx_b2", qat(wr_c, wb + 2), p + 4);
    check("rx_flag_t", qat(wr_c, wb + 3), p + 5);
    check("rx_rq_drop", int'(Dma_Rq), 0);

    // split frame
    push_byte(8'h01);
    wait_idle("split1", 0);
    compare_logs("split1");
    repeat (3) @(negedge Clk);
    push_byte(8'h02); push_byte(8'h03);
    wait_idle("split2", 0);
    compare_logs("split2");

    // TX
    tx_b0 = 8'hA5; tx_b1 = 8'h5A;
    rb = rd_a.size(); vb = vr_c.size(); s = cyc;
    Send = 1'b1;
    exp_tx.push_back(32'hA5); exp_tx.push_back(32'h5A);
    wait_idle("tx", 0);
    compare_logs("tx");
    check("tx_rd0", qat(rd_a, rb), int'(DMA_TX_BASE));
    check("tx_rd1", qat(rd_a, rb + 1), int'(DMA_TX_BASE) + 1);
    check("tx_lat", qat(rd_c, rb), s + 3);
    check("tx_valid_gap", int'(qat(vr_c, vb) - qat(rd_c, rb) >= 2), 1);

    // grant stall
    grant_en = 1'b0;
    wb = wr_a.size(); k = pops;
    push_byte(8'h7E); push_byte(8'h81); push_byte(8'hC3);
    repeat (5) @(negedge Clk);
    check("stall_nowr", wr_a.size(), wb);
    check("stall_nopop", pops, k);
    grant_en = 1'b1;
    wait_idle("stall", 0);
    compare_logs("stall");

    // RX priority over a simultaneous Send
    tx_b0 = 8'h3C; tx_b1 = 8'hC6;
    rb = rd_a.size(); wb = wr_a.size();
    push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
    Send = 1'b1;
    exp_tx.push_back(32'h3C); exp_tx.push_back(32'hC6);
    wait_idle("prio", 0);
    compare_logs("prio");
    check("prio_order", int'(qat(rd_c, rb) > qat(wr_c, wb + 3)), 1);
    check("prio_rd1", qat(rd_a, rb + 1), int'(DMA_TX_BASE) + 1);

    // reset after the second byte of a frame
    wb = wr_a.size();
    push_byte(8'h9A); push_byte(8'hBC); push_raw(8'hDE);
    k = 0;
    while (wr_a.size() < wb + 2 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    check("mid_two_writes", wr_a.size(), wb + 2);
    Rst = 1'b1;
    #1;
    check("mid_rst_bus", int'({Cs, Wen, Oen, Data_Read}), 0);
    check("mid_rst_rq", int'(Dma_Rq), 0);
    check("mid_rst_ready", int'(Ready), 0);
    rx_slot = 0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    compare_logs("mid_rst");
    push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3);
    wait_idle("after_rst", 0);
    compare_logs("after_rst");

    // randomized traffic with random grant gaps and transmitter stalls
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      do_send = $urandom_range(0, 1) == 1;
      if (do_send) begin
        tx_b0 = 8'($urandom); tx_b1 = 8'($urandom);
        exp_tx.push_back(int'(tx_b0)); exp_tx.push_back(int'(tx_b1));
        Send = 1'b1;
      end
      for (int n = $urandom_range(0, 4); n > 0; n--) begin
        b = 8'($urandom);
        push_byte(b);
      end
      wait_idle("rnd", 1);
      compare_logs("rnd");
    end

    check("bus_without_grant", bus_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma.md
# dma

Bus-master DMA engine sitting directly upstream of the data RAM. It drains bytes received by the serial link from the RX FIFO into the RAM receive buffer and raises the new-instruction flag. On CPU command it fetches two bytes from the RAM transmit buffer and hands them to the serial transmitter. It obtains the shared RAM bus from the CPU through a request/grant handshake and drives the RAM Cs/Wen/Oen/Address/DataIn lines while granted.

## Interface

Parameters:
- None. Addresses and state type come from `global_pkg`.

Ports:
- `Clk` in 1 — system clock; all logic on rising edge.
- `Rst` in 1 — reset, asynchronous, active-high.
- `RX_Data` in 8 — head byte of RX FIFO; valid whenever `RX_Empty`=0 (first-word fall-through).
- `RX_Empty` in 1 — RX FIFO empty.
- `Data_Read` out 1 — pop RX FIFO; one-cycle pulse.
- `Send` in 1 — CPU pulse: transmit RAM[DMA_TX_BASE], then RAM[DMA_TX_BASE+1].
- `Ready` out 1 — 1 when idle with no pending work.
- `TX_Data` out 8 — byte to transmitter.
- `Valid_D` out 1 — `TX_Data` valid; held until `Ack_out`.
- `Ack_out` in 1 — transmitter accepted byte.
- `TX_RDY` in 1 — transmitter idle, can take a new byte.
- `Dma_Rq` out 1 — bus request to CPU.
- `Dma_Ack` in 1 — bus grant; the DMA drives the RAM bus only while this is 1.
- `Cs` out 1 — RAM chip select, active-high.
- `Wen` out 1 — RAM write enable, active-high.
- `Oen` out 1 — RAM read enable, active-high.
- `Address` out 8 — RAM address.
- `DataOut` out 8 — write data to RAM.
- `DataIn` in 8 — RAM read data, valid the cycle after a `Cs`&`Oen` cycle.

## Operation

- States (`dma_state_t`): IDLE, RX_REQ, RX_WRITE, RX_FLAG, TX_REQ, TX_READ, TX_CAPT, TX_SEND, TX_WAIT.
- `Send` pulse is latched into `send_pend`. The latch is cleared on entry to TX_REQ.
- **IDLE:**
  - `RX_Empty`=0 → RX_REQ.
  - Else if `send_pend` → TX_REQ.
  - RX has priority over TX.
  - `Ready` = IDLE & RX_Empty & !send_pend.
- **RX_REQ:** `Dma_Rq`=1; wait for `Dma_Ack` → RX_WRITE.
- **RX_WRITE** (one cycle per byte):
  - Drive `Cs`=`Wen`=1, `Address`=DMA_RX_BASE+idx, `DataOut`=RX_Data, `Data_Read`=1; then idx++.
  - If idx was 2 → RX_FLAG.
  - Else if FIFO still non-empty (`RX_Empty` sampled after the pop) → stay in RX_WRITE.
  - Else → IDLE, releasing the bus.
- **RX_FLAG:** `Cs`=`Wen`=1, `Address`=NEW_INST, `DataOut`=8'hFF; idx←0 → IDLE.
- **idx:** 2-bit counter in 0..2. It persists across bus releases, so a 3-byte frame may arrive split across several grants.
- **TX_REQ:** `Dma_Rq`=1; on `Dma_Ack` → TX_READ.
- **TX_READ:** `Cs`=`Oen`=1, `Address`=DMA_TX_BASE+txi → TX_CAPT.
- **TX_CAPT:** latch `DataIn` into the TX_Data register → TX_SEND.
  - The bus stays held through TX_SEND and TX_WAIT.
- **TX_SEND:** wait for `TX_RDY`=1, then `Valid_D`=1 → TX_WAIT.
- **TX_WAIT:** hold `Valid_D` until `Ack_out`.
  - txi=0 → txi←1, TX_READ.
  - txi=1 → txi←0, IDLE.
- `Dma_Rq` is 1 in every state except IDLE.
- Loss of `Dma_Ack` while in a bus state:
  - Bus outputs are forced to 0.
  - The FSM freezes in place until the grant returns.
  - No pop and no write occur during the freeze.
- Bus outputs are 0 whenever the FSM is not in RX_WRITE, RX_FLAG or TX_READ.

## Timing

- Reset values:
  - All outputs = 0, including `Ready` (forced 0 while `Rst` asserted).
  - FSM = IDLE; idx = txi = 0; `send_pend` = 0.
  - `Ready` returns to 1 in the first cycle after `Rst` deasserts.
- RX latency: FIFO non-empty → first RAM write 2 cycles later with immediate grant. Each further byte takes 1 cycle.
- Flag write occurs the cycle after the 3rd data write.
- TX latency: `Send` → first RAM read in 3 cycles with immediate grant. `Valid_D` rises ≥2 cycles after the read.
- `Send` arriving during RX activity is latched and served after the RX path returns to IDLE.
- A `Send` while TX is busy is latched once; extra pulses merge.
- `Rst` mid-transfer aborts immediately:
  - Partial RX frame is discarded (idx←0).
  - No further pops or writes.

## Structure

- Add to `global_pkg`:
  - `DMA_RX_BASE`=8'h00, `NEW_INST`=8'h03, `DMA_TX_BASE`=8'h04.
  - `dma_state_t` enum.
- Single module, no sub-modules. One sequential block for state, counters and latches; one combinational block for next state and outputs.

## Test plan

- **RX frame:** FIFO holds 0x11,0x22,0x33, grant immediate → writes 0x11@00, 0x22@01, 0x33@02 on consecutive cycles, then 0xFF@03; 3 `Data_Read` pulses; `Dma_Rq` drops after the flag.
- **Split frame:** 1 byte, FIFO empties, then 2 bytes arrive later → bytes land at 00, then 01 and 02; flag written only after the 3rd byte.
- **TX:** RAM[04]=0xA5, RAM[05]=0x5A, `Send` pulse, `Ack_out` one cycle after each `Valid_D` → `TX_Data` shows 0xA5 then 0x5A; `Ready` returns to 1 afterwards.
- **Grant stall:** `Dma_Ack` held 0 for 5 cycles during RX → no `Cs`/`Data_Read` activity; bytes are written after the grant and no data is lost.
- **Priority:** `Send` pulse asserted in the same cycle FIFO becomes non-empty → RX write path completes first, then TX reads at 04/05.
- **Reset mid-RX:** `Rst` after the 2nd byte → outputs 0 immediately; next frame starts at address 00.
